// File: rtl/cf_pkg.sv
// Shared Connect Four board constants, drop FSM states and player encoding.
// The player encoding is also used by the per-cell LED controllers.
package cf_pkg;
  localparam int ROWS  = 8;
  localparam int COLS  = 8;
  localparam int ROW_W = 3;
  localparam int COL_W = 3;
  localparam int HGT_W = $clog2(ROWS + 1);

  typedef enum logic [1:0] {IDLE, FALL, COMMIT} drop_state_t;

  localparam logic PLAYER_RED = 1'b0;
  localparam logic PLAYER_GRN = 1'b1;
endpackage

// File: rtl/anim_tick.sv
// Row-hold divider for the falling-token animation.
// step pulses on the last cycle of each TICK_DIV-cycle row period.
module anim_tick #(
  parameter int TICK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic step
);
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] LAST = TW'(TICK_DIV - 1);

  logic [TW-1:0] tick;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      tick <= '0;
    end else if (en) begin
      tick <= (tick == LAST) ? '0 : tick + TW'(1);
    end
  end

  assign step = en && (tick == LAST);
endmodule

// File: rtl/drop_sequencer.sv
// Turn and drop controller: accepts a column, animates the token down the
// shared rowcounter, pulses commit at the landing cell, then swaps player.
module drop_sequencer
  import cf_pkg::*;
#(
  parameter int TICK_DIV = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             drop_req,
  input  logic [COL_W-1:0] drop_col,
  input  logic             game_over,
  output logic [ROW_W-1:0] rowcounter,
  output logic [COL_W-1:0] active_col,
  output logic             player,
  output logic             busy,
  output logic             commit,
  output logic [ROW_W-1:0] commit_row,
  output logic [COL_W-1:0] commit_col,
  output logic             reject,
  output logic [COLS-1:0]  col_full,
  output logic             board_full
);
  drop_state_t      state, state_n;
  logic [ROW_W-1:0] target, target_n;
  logic [ROW_W-1:0] row_n, commit_row_n;
  logic [COL_W-1:0] col_n, commit_col_n;
  logic             player_n, reject_n;
  logic [HGT_W-1:0] height   [COLS];
  logic [HGT_W-1:0] height_n [COLS];
  logic [COLS-1:0]  full_n;
  logic             step;

  anim_tick #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .clr   (state != FALL),
    .en    (state == FALL),
    .step  (step)
  );

  always_comb begin
    state_n      = state;
    target_n     = target;
    row_n        = rowcounter;
    col_n        = active_col;
    commit_row_n = commit_row;
    commit_col_n = commit_col;
    player_n     = player;
    reject_n     = 1'b0;
    height_n     = height;
    case (state)
      IDLE: begin
        if (drop_req && !game_over) begin
          if (col_full[drop_col]) begin
            reject_n = 1'b1;
          end else begin
            // Landing row counts up from the bottom by the column's fill level.
            col_n    = drop_col;
            target_n = ROW_W'(HGT_W'(ROWS - 1) - height[drop_col]);
            row_n    = '0;
            state_n  = FALL;
          end
        end
      end
      FALL: begin
        if (step) begin
          if (rowcounter == target) begin
            state_n      = COMMIT;
            commit_row_n = target;
            commit_col_n = active_col;
          end else begin
            row_n = rowcounter + ROW_W'(1);
          end
        end
      end
      COMMIT: begin
        height_n[active_col] = height[active_col] + HGT_W'(1);
        player_n = (player == PLAYER_RED) ? PLAYER_GRN : PLAYER_RED;
        state_n  = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    for (int c = 0; c < COLS; c++) begin
      full_n[c] = (height_n[c] == HGT_W'(ROWS));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      target     <= '0;
      rowcounter <= '0;
      active_col <= '0;
      player     <= PLAYER_RED;
      busy       <= 1'b0;
      commit     <= 1'b0;
      commit_row <= '0;
      commit_col <= '0;
      reject     <= 1'b0;
      col_full   <= '0;
      board_full <= 1'b0;
      for (int c = 0; c < COLS; c++) begin
        height[c] <= '0;
      end
    end else begin
      state      <= state_n;
      target     <= target_n;
      rowcounter <= row_n;
      active_col <= col_n;
      player     <= player_n;
      busy       <= (state_n != IDLE);
      commit     <= (state_n == COMMIT);
      commit_row <= commit_row_n;
      commit_col <= commit_col_n;
      reject     <= reject_n;
      col_full   <= full_n;
      board_full <= &full_n;
      height     <= height_n;
    end
  end
endmodule

// File: tb/tb_drop_sequencer.sv
// Bench for drop_sequencer: hand-computed drop table, corner sequences and
// randomized requests against a column-height model.
module tb_drop_sequencer;
  import cf_pkg::*;

  localparam int TD = 2;

  logic             clk = 1'b0;
  logic             reset, drop_req, game_over;
  logic [COL_W-1:0] drop_col, active_col, commit_col;
  logic [ROW_W-1:0] rowcounter, commit_row;
  logic             player, busy, commit, reject, board_full;
  logic [COLS-1:0]  col_full;

  int total_cnt = 0;
  int pass_cnt  = 0;
  int hgt [COLS];
  logic mplayer;

  typedef struct {
    int col;
    int exp_row;
    int exp_player;
  } drop_vec_t;
  drop_vec_t vecs [10];

  always #5 clk = ~clk;

  drop_sequencer #(.TICK_DIV(TD)) dut (
    .clk        (clk),
    .reset      (reset),
    .drop_req   (drop_req),
    .drop_col   (drop_col),
    .game_over  (game_over),
    .rowcounter (rowcounter),
    .active_col (active_col),
    .player     (player),
    .busy       (busy),
    .commit     (commit),
    .commit_row (commit_row),
    .commit_col (commit_col),
    .reject     (reject),
    .col_full   (col_full),
    .board_full (board_full)
  );

  task automatic chk(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic int model_full();
    int v = 0;
    for (int c = 0; c < COLS; c++) if (hgt[c] == ROWS) v |= (1 << c);
    return v;
  endfunction

  task automatic model_clear();
    for (int c = 0; c < COLS; c++) hgt[c] = 0;
    mplayer = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_rowcounter"}, int'(rowcounter), 0);
    chk({tag, "_active_col"}, int'(active_col), 0);
    chk({tag, "_player"},     int'(player), 0);
    chk({tag, "_busy"},       int'(busy), 0);
    chk({tag, "_commit"},     int'(commit), 0);
    chk({tag, "_commit_row"}, int'(commit_row), 0);
    chk({tag, "_commit_col"}, int'(commit_col), 0);
    chk({tag, "_reject"},     int'(reject), 0);
    chk({tag, "_col_full"},   int'(col_full), 0);
    chk({tag, "_board_full"}, int'(board_full), 0);
  endtask

  // One full drop, checked cycle by cycle. Optionally a second request
  // (intr_col >= 0) or game_over is raised a few cycles into the fall.
  task automatic do_drop(input int col, input int exp_row, input int exp_player,
                         input int intr_col, input bit go_mid);
    int fall_cycles = (exp_row + 1) * TD;
    @(negedge clk);
    drop_col = COL_W'(col);
    drop_req = 1'b1;
    @(negedge clk);
    drop_req = 1'b0;
    for (int n = 0; n < fall_cycles; n++) begin
      chk("fall_busy", int'(busy), 1);
      chk("fall_row", int'(rowcounter), n / TD);
      chk("fall_col", int'(active_col), col);
      chk("fall_no_commit", int'(commit), 0);
      chk("fall_no_reject", int'(reject), 0);
      if (n == 3 && intr_col >= 0) begin
        drop_req = 1'b1;
        drop_col = COL_W'(intr_col);
      end else begin
        drop_req = 1'b0;
      end
      if (n == 3 && go_mid) game_over = 1'b1;
      @(negedge clk);
    end
    drop_req = 1'b0;
    chk("commit_pulse", int'(commit), 1);
    chk("commit_row", int'(commit_row), exp_row);
    chk("commit_col", int'(commit_col), col);
    chk("commit_player", int'(player), exp_player);
    chk("commit_busy", int'(busy), 1);
    chk("commit_rowcounter", int'(rowcounter), exp_row);
    @(negedge clk);
    chk("post_commit_low", int'(commit), 0);
    chk("post_busy_low", int'(busy), 0);
    chk("post_player", int'(player), 1 - exp_player);
    game_over = 1'b0;
  endtask

  // Request handled by the model: ignored, rejected or dropped.
  task automatic run_req(input int col, input bit go);
    @(negedge clk);
    if (go) begin
      game_over = 1'b1;
      drop_col  = COL_W'(col);
      drop_req  = 1'b1;
      @(negedge clk);
      drop_req = 1'b0;
      chk("go_busy", int'(busy), 0);
      chk("go_reject", int'(reject), 0);
      @(negedge clk);
      chk("go_busy2", int'(busy), 0);
      chk("go_player", int'(player), int'(mplayer));
      game_over = 1'b0;
    end else if (hgt[col] == ROWS) begin
      drop_col = COL_W'(col);
      drop_req = 1'b1;
      @(negedge clk);
      drop_req = 1'b0;
      chk("reject_pulse", int'(reject), 1);
      chk("reject_busy", int'(busy), 0);
      @(negedge clk);
      chk("reject_one_cycle", int'(reject), 0);
      chk("reject_busy2", int'(busy), 0);
      chk("reject_player", int'(player), int'(mplayer));
    end else begin
      do_drop(col, ROWS - 1 - hgt[col], int'(mplayer), -1, 1'b0);
      hgt[col]++;
      mplayer = ~mplayer;
    end
    chk("col_full", int'(col_full), model_full());
    chk("board_full", int'(board_full), (model_full() == (1 << COLS) - 1) ? 1 : 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int commits_seen;
    vecs[0] = '{3, 7, 0};
    vecs[1] = '{3, 6, 1};
    vecs[2] = '{0, 7, 0};
    vecs[3] = '{0, 6, 1};
    vecs[4] = '{0, 5, 0};
    vecs[5] = '{0, 4, 1};
    vecs[6] = '{0, 3, 0};
    vecs[7] = '{0, 2, 1};
    vecs[8] = '{0, 1, 0};
    vecs[9] = '{0, 0, 1};

    reset = 1'b1; drop_req = 1'b0; game_over = 1'b0; drop_col = '0;
    model_clear();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check_reset_vals("reset");

    // Hand-computed drops: two in column 3, eight filling column 0.
    for (int i = 0; i < 10; i++) begin
      do_drop(vecs[i].col, vecs[i].exp_row, vecs[i].exp_player, -1, 1'b0);
      hgt[vecs[i].col]++;
      mplayer = ~mplayer;
    end
    chk("col0_full", int'(col_full), 1);
    chk("not_board_full", int'(board_full), 0);
    run_req(0, 1'b0);

    // Request during an animation is dropped; column 5 stays empty.
    do_drop(2, ROWS - 1 - hgt[2], int'(mplayer), 5, 1'b0);
    hgt[2]++;
    mplayer = ~mplayer;
    chk("col5_untouched_row", ROWS - 1 - hgt[5], 7);
    run_req(5, 1'b0);

    // game_over: idle request ignored, mid-fall drop still completes.
    run_req(4, 1'b1);
    do_drop(6, ROWS - 1 - hgt[6], int'(mplayer), -1, 1'b1);
    hgt[6]++;
    mplayer = ~mplayer;
    chk("go_mid_col_full", int'(col_full), model_full());

    // Reset in the middle of a fall.
    @(negedge clk);
    drop_col = 3'd6;
    drop_req = 1'b1;
    @(negedge clk);
    drop_req = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_reset_vals("mid_reset");
    commits_seen = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (commit || busy) commits_seen++;
    end
    chk("no_activity_after_reset", commits_seen, 0);
    model_clear();
    run_req(3, 1'b0);

    // Randomized requests, biased to a few columns so some fill up.
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      run_req(int'($urandom_range(0, 3)), ($urandom_range(0, 5) == 0));
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
